pio_hex_scroll_ctrl: RTL

- Sequencer between the HPS PIO exports and the six on-board seven-segment displays.
- Takes the 32-bit hex word and 10-bit speed word written by software.
- Either shows the low 6 nibbles statically, or scrolls all 8 nibbles as a rotating marquee at a software-set step rate.
- Detects new values, restarts the scroll and drives registered segment patterns.

---
 rtl/pio_hex_scroll_if.sv | 12 +
 rtl/pio_hex_scroll_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pio_hex_scroll_if.sv
// Bus between the HPS PIO exports and the hex display sequencer.
interface pio_hex_scroll_if;
  logic [31:0] hex_value;
  logic [9:0]  speed;
  logic [41:0] hex_seg;
  logic [2:0]  offset;
  logic        busy;
  logic        update_pulse;

  modport master (output hex_value, speed, input hex_seg, offset, busy, update_pulse);
  modport slave  (input hex_value, speed, output hex_seg, offset, busy, update_pulse);
endinterface

// File: rtl/pio_hex_scroll_ctrl.sv
// Static / marquee sequencer from the PIO hex+speed words to six 7-seg digits.
// Define HEX_LZ_BLANK_EN to blank leading zeros in static mode.
module pio_hex_seg_enc #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  logic [6:0] code;

  always_comb begin
    code = 7'h00;
    case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h6F;
      4'hA: code = 7'h77;
      4'hB: code = 7'h7C;
      4'hC: code = 7'h39;
      4'hD: code = 7'h5E;
      4'hE: code = 7'h79;
      default: code = 7'h71;
    endcase
  end

  assign seg = blank ? (SEG_ACTIVE_LOW ? 7'h7F : 7'h00)
                     : (SEG_ACTIVE_LOW ? ~code : code);
endmodule

module pio_hex_scroll_ctrl #(
  parameter int TICK_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic clk_clk,
  input  logic reset_reset,
  pio_hex_scroll_if.slave bus
);
  localparam int NUM_LANES = 6;
  localparam int PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {S_STATIC, S_SCROLL, S_RELOAD} state_t;

  state_t      state, state_nxt;
  logic [31:0] shadow, shadow_nxt;
  logic [2:0]  off_q, off_nxt;
  logic [9:0]  step_cnt, step_nxt;
  logic [PW-1:0] presc;
  logic        tick, chg, upd_q;

  logic [NUM_LANES-1:0][3:0] win;
  logic [NUM_LANES-1:0]      blank;
  logic [NUM_LANES-1:0][6:0] seg_d, seg_q;

  assign tick = (presc == PW'(TICK_DIV - 1));
  assign chg  = (bus.hex_value != shadow);

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    off_nxt    = off_q;
    step_nxt   = step_cnt;
    case (state)
      S_STATIC: begin
        if (chg) state_nxt = S_RELOAD;
        else if (bus.speed != 10'd0) begin
          state_nxt = S_SCROLL;
          off_nxt   = 3'd0;
          step_nxt  = 10'd0;
        end
      end
      S_SCROLL: begin
        // a change wins over a coincident step, so the marquee restarts at 0
        if (chg) begin
          state_nxt = S_RELOAD;
          off_nxt   = 3'd0;
          step_nxt  = 10'd0;
        end else if (bus.speed == 10'd0) begin
          state_nxt = S_STATIC;
          off_nxt   = 3'd0;
          step_nxt  = 10'd0;
        end else if (tick) begin
          if (({1'b0, step_cnt} + 11'd1) >= {1'b0, bus.speed}) begin
            off_nxt  = off_q + 3'd1;
            step_nxt = 10'd0;
          end else begin
            step_nxt = step_cnt + 10'd1;
          end
        end
      end
      S_RELOAD: begin
        shadow_nxt = bus.hex_value;
        off_nxt    = 3'd0;
        step_nxt   = 10'd0;
        state_nxt  = (bus.speed != 10'd0) ? S_SCROLL : S_STATIC;
      end
      default: state_nxt = S_STATIC;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state    <= S_STATIC;
      shadow   <= '0;
      off_q    <= '0;
      step_cnt <= '0;
      presc    <= '0;
      upd_q    <= 1'b0;
      seg_q    <= {NUM_LANES{SEG_OFF}};
    end else begin
      presc    <= tick ? '0 : presc + PW'(1);
      state    <= state_nxt;
      shadow   <= shadow_nxt;
      off_q    <= off_nxt;
      step_cnt <= step_nxt;
      upd_q    <= (state == S_RELOAD);
      seg_q    <= seg_d;
    end
  end

  // offset is held at 0 outside scrolling, so one rotating window serves both modes
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [2:0] idx;
    assign idx    = off_q + 3'(i);
    assign win[i] = shadow[{idx, 2'b00} +: 4];
    pio_hex_seg_enc #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc (
      .nib   (win[i]),
      .blank (blank[i]),
      .seg   (seg_d[i])
    );
  end

`ifdef HEX_LZ_BLANK_EN
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lz
    if (i == 0) begin : g_keep
      assign blank[i] = 1'b0;
    end else begin : g_blank
      assign blank[i] = (state == S_STATIC) && !(|win[NUM_LANES-1:i]);
    end
  end
`else
  assign blank = '0;
`endif

  assign bus.hex_seg      = seg_q;
  assign bus.offset       = off_q;
  assign bus.busy         = (state == S_SCROLL);
  assign bus.update_pulse = upd_q;
endmodule
